// File: rtl/arm_job_sequencer.sv
// Pick-and-place job sequencer: a 4-deep (x, y, z) job FIFO feeding a timed
// table / claw / arm phase machine that drives arm_model and pwm_fre controls.
module arm_job_sequencer #(
    parameter logic [31:0] HOME_X  = 32'd289057,
    parameter logic [31:0] HOME_Y  = 32'd1639325,
    parameter logic [31:0] T_TABLE = 32'd500_000_000,
    parameter logic [31:0] T_ARM   = 32'd100_000_000,
    parameter logic [31:0] T_GRIP  = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    input  logic [31:0] job_x,
    input  logic [31:0] job_y,
    input  logic [31:0] job_z,
    output logic        job_ready,
    input  logic        abort,
    output logic [31:0] arm_x,
    output logic [31:0] arm_y,
    output logic        arm_en1,
    output logic        arm_en2,
    output logic        catch,
    output logic        table_start,
    output logic        table_back,
    output logic [31:0] table_dest,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        uart_clr,
    output logic [2:0]  job_count
);
    // Phase lengths below 2 cycles would collapse the one-cycle pulses, so clamp.
    localparam logic [31:0] TT_M1 = ((T_TABLE < 32'd2) ? 32'd2 : T_TABLE) - 32'd1;
    localparam logic [31:0] TA_M1 = ((T_ARM   < 32'd2) ? 32'd2 : T_ARM)   - 32'd1;
    localparam logic [31:0] TG_M1 = ((T_GRIP  < 32'd2) ? 32'd2 : T_GRIP)  - 32'd1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_HOME   = 4'd1;
    localparam logic [3:0] S_TRAVEL = 4'd2;
    localparam logic [3:0] S_OPEN   = 4'd3;
    localparam logic [3:0] S_REACH  = 4'd4;
    localparam logic [3:0] S_GRIP   = 4'd5;
    localparam logic [3:0] S_STOW   = 4'd6;
    localparam logic [3:0] S_RETURN = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;
    localparam logic [3:0] S_ABORT  = 4'd9;

    logic [95:0] mem_q [0:3];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ready_q, ready_d;
    logic [3:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d, limit_s;
    logic [31:0] jx_q, jx_d, jy_q, jy_d, jz_q, jz_d;
    logic [31:0] arm_x_q, arm_x_d, arm_y_q, arm_y_d, dest_q, dest_d;
    logic        catch_q, catch_d, start_q, start_d, back_q, back_d;
    logic        busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic        uart_clr_q, uart_clr_d, en1_q, en2_q;
    logic        push_s, pop_s, in_job_s, entering_s;

    // An asserted abort flushes the queue and blocks both push and pop.
    assign push_s   = job_valid && (count_q != 3'd4) && !abort;
    assign pop_s    = (state_q == S_IDLE) && (count_q != 3'd0) && !abort;
    assign in_job_s = (state_q >= S_HOME) && (state_q <= S_RETURN);

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        jx_d     = jx_q;
        jy_d     = jy_q;
        jz_d     = jz_q;
        if (abort) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            wr_ptr_d = wr_ptr_q + {1'b0, push_s};
            rd_ptr_d = rd_ptr_q + {1'b0, pop_s};
            count_d  = count_q + {2'b00, push_s} - {2'b00, pop_s};
        end
        if (pop_s) begin
            {jx_d, jy_d, jz_d} = mem_q[rd_ptr_q];
        end else begin
            jx_d = jx_q;
        end
        ready_d = (count_d != 3'd4);
    end

    // Phase length of the current state.
    always_comb begin
        case (state_q)
            S_HOME, S_TRAVEL, S_RETURN: limit_s = TT_M1;
            S_OPEN, S_GRIP:             limit_s = TG_M1;
            S_REACH, S_STOW, S_ABORT:   limit_s = TA_M1;
            default:                    limit_s = 32'd0;
        endcase
    end

    // Next-state logic; abort overrides the normal phase exit.
    always_comb begin
        state_d = state_q;
        if (in_job_s && abort) begin
            state_d = S_ABORT;
        end else if (state_q == S_IDLE) begin
            state_d = pop_s ? S_HOME : S_IDLE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (cnt_q == limit_s) begin
            case (state_q)
                S_HOME:   state_d = S_TRAVEL;
                S_TRAVEL: state_d = S_OPEN;
                S_OPEN:   state_d = S_REACH;
                S_REACH:  state_d = S_GRIP;
                S_GRIP:   state_d = S_STOW;
                S_STOW:   state_d = S_RETURN;
                S_RETURN: state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        entering_s = (state_d != state_q);
        cnt_d      = (entering_s || (state_q == S_IDLE)) ? 32'd0 : cnt_q + 32'd1;
    end

    // Registered outputs are set on state entry so each pulse covers cnt == 0.
    always_comb begin
        arm_x_d    = arm_x_q;
        arm_y_d    = arm_y_q;
        dest_d     = dest_q;
        catch_d    = catch_q;
        start_d    = 1'b1;
        back_d     = 1'b1;
        done_d     = (state_q == S_DONE);
        aborted_d  = (state_q == S_ABORT) && (state_d == S_IDLE);
        uart_clr_d = done_d || aborted_d;
        busy_d     = (state_d != S_IDLE);
        if (entering_s) begin
            case (state_d)
                S_HOME:   back_d = 1'b0;
                S_TRAVEL: begin start_d = 1'b0; dest_d = jz_q; end
                S_OPEN:   catch_d = 1'b1;
                S_REACH:  begin arm_x_d = jx_q; arm_y_d = jy_q; end
                S_GRIP:   catch_d = 1'b0;
                S_STOW:   begin arm_x_d = HOME_X; arm_y_d = HOME_Y; end
                S_RETURN: back_d = 1'b0;
                S_ABORT:  begin
                    back_d  = 1'b0;
                    catch_d = 1'b0;
                    arm_x_d = HOME_X;
                    arm_y_d = HOME_Y;
                end
                default:  back_d = 1'b1;
            endcase
        end else begin
            back_d = 1'b1;
        end
    end

    // Job storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {job_x, job_y, job_z};
        end
    end

    // State, timer, FIFO control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            ready_q    <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 32'd0;
            jx_q       <= 32'd0;
            jy_q       <= 32'd0;
            jz_q       <= 32'd0;
            arm_x_q    <= HOME_X;
            arm_y_q    <= HOME_Y;
            dest_q     <= 32'd0;
            catch_q    <= 1'b0;
            start_q    <= 1'b1;
            back_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            uart_clr_q <= 1'b0;
            en1_q      <= 1'b1;
            en2_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            jx_q       <= jx_d;
            jy_q       <= jy_d;
            jz_q       <= jz_d;
            arm_x_q    <= arm_x_d;
            arm_y_q    <= arm_y_d;
            dest_q     <= dest_d;
            catch_q    <= catch_d;
            start_q    <= start_d;
            back_q     <= back_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            uart_clr_q <= uart_clr_d;
            en1_q      <= 1'b1;
            en2_q      <= 1'b0;
        end
    end

    assign job_ready   = ready_q;
    assign job_count   = count_q;
    assign arm_x       = arm_x_q;
    assign arm_y       = arm_y_q;
    assign arm_en1     = en1_q;
    assign arm_en2     = en2_q;
    assign catch       = catch_q;
    assign table_start = start_q;
    assign table_back  = back_q;
    assign table_dest  = dest_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign uart_clr    = uart_clr_q;
endmodule
